// File: rtl/wb_queue.sv
// wb_queue -- in-order register-file write-back queue with read bypass.
//
// Two result sources (A: ALU, B: mult/div) compete for one enqueue slot per
// cycle; A has fixed priority. Entries drain to the register file one per
// cycle (the register file always accepts). Pending entries are searched for
// the two read addresses so that operand reads see the newest value.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   a_valid/a_reg/a_data/a_ready source A handshake
//   b_valid/b_reg/b_data/b_ready source B handshake
//   regW/regWrite/dataWrite      register file write port (head entry)
//   regRead1/regRead2            register file read addresses this cycle
//   fwd1_hit/fwd1_data           bypass result for regRead1
//   fwd2_hit/fwd2_data           bypass result for regRead2
//   count/full/empty             occupancy status
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  output logic                     b_ready,
  output logic                     regW,
  output logic [4:0]               regWrite,
  output logic [31:0]              dataWrite,
  input  logic [4:0]               regRead1,
  input  logic [4:0]               regRead2,
  output logic                     fwd1_hit,
  output logic [31:0]              fwd1_data,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    reg_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push, pop;
  logic [4:0]    in_reg;
  logic [31:0]   in_data;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign a_ready = !full;
  assign b_ready = !full && !a_valid;

  assign regW      = !empty;
  assign regWrite  = reg_q[head_q];
  assign dataWrite = data_q[head_q];

  // A handshake with register 0 completes but is dropped here.
  always_comb begin
    push    = 1'b0;
    in_reg  = a_reg;
    in_data = a_data;
    if (a_valid && a_ready) begin
      push = (a_reg != 5'd0);
    end else if (b_valid && b_ready) begin
      push    = (b_reg != 5'd0);
      in_reg  = b_reg;
      in_data = b_data;
    end
  end

  assign pop = !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        reg_q[tail_q]  <= in_reg;
        data_q[tail_q] <= in_data;
      end
    end
  end

  // Scan from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [AW-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (CW'(k) < count_q) begin
        if (regRead1 != 5'd0 && reg_q[idx] == regRead1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if (regRead2 != 5'd0 && reg_q[idx] == regRead2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Parameters
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of pending write entries (power of two, 2..16).

Interface
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port a_valid, input, 1: source A (ALU path) has a result.
REQ-005 SHALL have port a_reg, input, 5: source A destination register.
REQ-006 SHALL have port a_data, input, 32: source A result.
REQ-007 SHALL have port a_ready, output, 1: source A accepted this cycle when high together with a_valid.
REQ-008 SHALL have port b_valid, input, 1: source B (mult/div path) has a result.
REQ-009 SHALL have ports b_reg (input, 5), b_data (input, 32) and b_ready (output, 1), with the same meaning as the A ports.
REQ-010 SHALL have port regW, output, 1: register file write enable.
REQ-011 SHALL have port regWrite, output, 5: register file write address.
REQ-012 SHALL have port dataWrite, output, 32: register file write data.
REQ-013 SHALL have ports regRead1 and regRead2, input, 5 each: the register file read addresses being issued this cycle.
REQ-014 SHALL have ports fwd1_hit (output, 1) and fwd1_data (output, 32): pending-write bypass for regRead1.
REQ-015 SHALL have ports fwd2_hit (output, 1) and fwd2_data (output, 32): pending-write bypass for regRead2.
REQ-016 SHALL have ports count (output, log2(DEPTH)+1), full (output, 1) and empty (output, 1).

Function
REQ-017 SHALL hold entries as an in-order circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-018 SHALL accept at most one entry per cycle. a_ready = !full. b_ready = !full && !a_valid, so A has fixed priority over B.
REQ-019 SHALL complete an accepted handshake (valid && ready) with reg address 0 without enqueuing anything; register 0 is never written.
REQ-020 SHALL drive regW = !empty, with regWrite and dataWrite taken from the head entry as combinational outputs.
REQ-021 SHALL pop the head entry on every cycle in which regW = 1; the register file accepts unconditionally.
REQ-022 SHALL present an entry accepted in cycle N on regW no earlier than cycle N+1; there is no same-cycle pass-through.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL drive full = (count == DEPTH) and empty = (count == 0).
REQ-025 SHALL compare each of regRead1 and regRead2 against all valid entries, including the head. On one or more matches it SHALL assert fwdN_hit with fwdN_data taken from the youngest matching entry.
REQ-026 SHALL hold fwdN_hit = 0 and fwdN_data = 0 when regReadN is 0 or there is no match. The bypass SHALL ignore the write being presented on the input ports in the same cycle.
REQ-027 SHALL keep all bypass and write-port outputs combinational from the registered FIFO state.

Reset
REQ-028 SHALL, when rst = 1 at a clock edge, clear head, tail and count to 0 and discard all entries; the entry data contents need not be cleared.
REQ-029 SHALL, in the cycle after reset, have regW = 0, full = 0, empty = 1, count = 0, both fwd hits 0, a_ready = 1, and b_ready = !a_valid.
REQ-030 SHALL ignore a handshake presented in the same cycle as rst = 1; nothing is enqueued.

Verification
REQ-031 Single write: A writes r5 = 0x1234 in cycle 0 -> cycle 1 shows regW = 1, regWrite = 5, dataWrite = 0x1234; cycle 2 shows regW = 0 and empty = 1.
REQ-032 Arbitration: A (r1 = 0xA) and B (r2 = 0xB) both valid in cycle 0 -> a_ready = 1, b_ready = 0. B holds and is accepted in cycle 1. Writes appear in cycles 1 and 2 in order r1, r2.
REQ-033 Bypass ordering: enqueue r7 = 0x1 in cycle 0 and r7 = 0x2 in cycle 1, with no further pushes. The bench SHALL observe regRead1 = 7 in cycle 1 -> fwd1_hit = 1, fwd1_data = 0x1 (only the first entry is in the FIFO). After the first entry pops, in cycle 2 -> fwd1_data = 0x2. After the second entry pops, in cycle 3 -> fwd1_hit = 0.
REQ-034 Full and wrap: with DEPTH = 4, push in every cycle. Because one entry pops per cycle, count never exceeds 1. The bench SHALL therefore force a full condition by checking that the count and full logic reach 4 under a forced stall build option, or SHALL cover wrap by running 9 pushes and checking in-order output, pointer wrap and no loss.
REQ-035 Reg zero: A writes r0 = 0xFFFF -> a_ready = 1, regW stays 0, and regRead1 = 0 gives fwd1_hit = 0.
REQ-036 Reset mid-operation: with 2 entries pending, assert rst for one cycle -> in the next cycle regW = 0, empty = 1 and count = 0; the pending writes never reach the register file.
